// File: rtl/deserializer_sipo.sv
// Serial-in parallel-out deserializer: LSB-first framed bit stream into DATA_WIDTH-bit words,
// with a one-word output holding register, sticky overrun and frame-restart error pulse.
module deserializer_sipo #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  srl_in,
  input  logic                  shift,
  input  logic                  frame_start,
  input  logic                  data_ack,
  input  logic                  clr_ovr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  RX_active,
  output logic                  overrun,
  output logic                  frame_err
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_sr;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_valid;
  logic                  r_ovr;
  logic                  r_ferr;

  logic [DATA_WIDTH-1:0] w_sr_next;
  logic                  w_in_shift;
  logic                  w_accept;
  logic                  w_restart;
  logic                  w_complete;
  logic                  w_drop;

  assign w_in_shift = (r_state == SHIFT);
  assign w_sr_next  = {srl_in, r_sr[DATA_WIDTH-1:1]};
  assign w_accept   = shift && (w_in_shift || frame_start);
  assign w_restart  = shift && frame_start && w_in_shift;
  assign w_complete = shift && !frame_start && w_in_shift && (r_cnt == LAST_CNT);
  // A completed word is lost only if the previous one is still unconsumed this cycle.
  assign w_drop     = w_complete && r_valid && !data_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sr    <= '0;
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_ferr <= w_restart;

      if (w_accept) begin
        r_sr <= w_sr_next;
      end

      case (r_state)
        IDLE: begin
          if (shift && frame_start) begin
            r_cnt   <= ONE_CNT;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (shift) begin
            if (frame_start) begin
              r_cnt <= ONE_CNT;
            end else if (r_cnt == LAST_CNT) begin
              r_cnt   <= '0;
              r_state <= IDLE;
            end else begin
              r_cnt <= r_cnt + ONE_CNT;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase

      // Word is presented on the same edge that samples its final bit.
      if (w_complete && !w_drop) begin
        r_dout  <= w_sr_next;
        r_valid <= 1'b1;
      end else if (data_ack) begin
        r_valid <= 1'b0;
      end

      if (w_drop) begin
        r_ovr <= 1'b1;
      end else if (clr_ovr) begin
        r_ovr <= 1'b0;
      end
    end
  end

  assign data_out   = r_dout;
  assign data_valid = r_valid;
  assign RX_active  = w_in_shift;
  assign overrun    = r_ovr;
  assign frame_err  = r_ferr;

endmodule
